// File: rtl/stopwatch_ctrl.sv
// Stopwatch/timer core: debounces start/clear buttons, runs a start/pause/clear
// FSM and keeps a 4-digit BCD MM:SS count that runs up or down.
module stopwatch_ctrl #(
  parameter int DB_SAMPLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sec_tick,
  input  logic        db_tick,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        sw_down,
  input  logic [15:0] load_bcd,
  output logic [15:0] bcd,
  output logic        running,
  output logic        done,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Button index 0 = start, 1 = clear.
  logic [1:0]            sync1_q, sync2_q;
  logic [DB_SAMPLES-1:0] sh_q [2];
  logic [DB_SAMPLES-1:0] vld_q;
  logic [1:0]            lvl_q, lvl_prev_q, armed_q;
  logic [1:0]            press;

  state_t      state_q, state_d;
  logic [15:0] bcd_q, bcd_d;
  logic        dir_q, dir_d;

  function automatic logic [15:0] clear_val(input logic down, input logic [15:0] ld);
    logic [3:0] mt, mo, st, so;
    mt = (ld[15:12] > 4'd9) ? 4'd9 : ld[15:12];
    mo = (ld[11:8]  > 4'd9) ? 4'd9 : ld[11:8];
    st = (ld[7:4]   > 4'd5) ? 4'd5 : ld[7:4];
    so = (ld[3:0]   > 4'd9) ? 4'd9 : ld[3:0];
    return down ? {mt, mo, st, so} : 16'h0000;
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 4'd9) so = so + 4'd1;
    else begin
      so = 4'd0;
      if (st != 4'd5) st = st + 4'd1;
      else begin
        st = 4'd0;
        if (mo != 4'd9) mo = mo + 4'd1;
        else begin
          mo = 4'd0;
          mt = mt + 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 4'd0) so = so - 4'd1;
    else begin
      so = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mo != 4'd0) mo = mo - 4'd1;
        else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  // armed_q blocks a press until a full window of released samples has been
  // seen since reset, so a button held through reset never fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sh_q[0]    <= '0;
      sh_q[1]    <= '0;
      vld_q      <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      armed_q    <= '0;
    end else begin
      sync1_q    <= {btn_clear, btn_start};
      sync2_q    <= sync1_q;
      lvl_prev_q <= lvl_q;
      if (db_tick) begin
        vld_q <= {vld_q[DB_SAMPLES-2:0], 1'b1};
        for (int b = 0; b < 2; b++) sh_q[b] <= {sh_q[b][DB_SAMPLES-2:0], sync2_q[b]};
      end
      for (int b = 0; b < 2; b++) begin
        if (&sh_q[b])       lvl_q[b] <= 1'b1;
        else if (~|sh_q[b]) lvl_q[b] <= 1'b0;
        if ((&vld_q) && (~|sh_q[b])) armed_q[b] <= 1'b1;
      end
    end
  end

  assign press = lvl_q & ~lvl_prev_q & armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    dir_d   = dir_q;
    if (press[1]) begin
      state_d = IDLE;
      bcd_d   = clear_val(sw_down, load_bcd);
    end else begin
      case (state_q)
        IDLE: begin
          if (press[0]) begin
            if (sw_down && (bcd_q == 16'h0000)) state_d = DONE;
            else begin
              dir_d   = sw_down;
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (press[0]) state_d = PAUSE;
          else if (sec_tick) begin
            // Terminal values are guarded so the count can never wrap.
            if (!dir_q) begin
              if (bcd_q == 16'h9959) state_d = DONE;
              else begin
                bcd_d = bcd_inc(bcd_q);
                if (bcd_d == 16'h9959) state_d = DONE;
              end
            end else begin
              if (bcd_q == 16'h0000) state_d = DONE;
              else begin
                bcd_d = bcd_dec(bcd_q);
                if (bcd_d == 16'h0000) state_d = DONE;
              end
            end
          end
        end
        PAUSE: begin
          if (press[0]) state_d = RUN;
        end
        default: ;
      endcase
    end
  end

  assign bcd     = bcd_q;
  assign state   = state_q;
  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Stopwatch/timer core fed by the clock divider's single-cycle tick outputs: sec_tick (1 s) and db_tick (25 ms).
- Debounces two push-buttons, runs a start/pause/clear FSM, and keeps a 4-digit BCD MM:SS count, up or down.
- Drives the BCD value to the display multiplexer, which runs off disp_clk.

Parameters:
DB_SAMPLES, 2, consecutive identical db_tick samples needed to change a debounced button level (range 2..8).

Ports:
clk  in  1  system clock, 100 MHz.
rst_n  in  1  asynchronous active-low reset.
sec_tick  in  1  one-clk pulse once per second from the divider.
db_tick  in  1  one-clk pulse every 25 ms from the divider.
btn_start  in  1  raw start/pause button, asynchronous.
btn_clear  in  1  raw clear button, asynchronous.
sw_down  in  1  count direction: 1 = down, 0 = up.
load_bcd  in  16  down-count preset {min_t,min_o,sec_t,sec_o}.
bcd  out  16  current count {min_t,min_o,sec_t,sec_o}.
running  out  1  high in RUN.
done  out  1  high in DONE.
state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
Reset (rst_n low, asynchronous):
- bcd=0000, state=IDLE, running=0, done=0.
- Synchronisers, debounce shift registers, debounced levels and the direction latch all clear to 0.

Input conditioning (per button):
- 2-flop synchroniser.
- Sampled into a DB_SAMPLES-deep shift register only on db_tick.
- Debounced level goes to 1 when all samples are 1, to 0 when all are 0, otherwise holds.
- Press pulse: 1-clk pulse on the debounced level's 0->1 edge, asserted the clk after the level update.
- Releases generate nothing. Holding a button generates exactly one pulse.

Clear value:
- 0000 when sw_down=0.
- load_bcd when sw_down=1, with any load_bcd digit above 9 replaced by 9, and sec_t above 5 replaced by 5.

FSM (state and bcd registered; outputs are register values, no combinational path from inputs):
- IDLE, start press: latch dir=sw_down, go RUN.
- IDLE, start press, sw_down=1 and bcd=0000: go DONE instead.
- RUN, start press: go PAUSE.
- PAUSE, start press: go RUN. dir is not re-latched.
- DONE, start press: ignored.
- Clear press in any state: go IDLE, bcd=clear value.
- Clear press in IDLE also reloads bcd.
- sec_tick in RUN, dir=0: increment MM:SS.
  - sec_o wraps 9->0 with carry into sec_t; sec_t wraps 5->0 with carry into min_o; min_o wraps 9->0 with carry into min_t.
  - Update 99:58->99:59 also enters DONE. Count never wraps past 99:59.
- sec_tick in RUN, dir=1: decrement with symmetric borrows; sec_t borrows 0->5.
  - Update 00:01->00:00 also enters DONE.
- sec_tick outside RUN: ignored.
- sw_down changes while not in IDLE: no effect.

Latency:
- bcd changes on the clk edge after the sec_tick cycle.
- First count after start occurs on the next sec_tick, so up to 1 s of phase error is accepted.

Simultaneous events:
- Clear and start presses in the same cycle: clear wins.
- Start press (RUN->PAUSE) and sec_tick in the same cycle: go PAUSE, tick dropped.
- PAUSE->RUN and sec_tick in the same cycle: go RUN, no count that cycle.
- Reset mid-count: immediate return to reset values. No press pulse is produced after reset unless the button has been observed released (debounced 0) first.

Test Plan:
1. DB_SAMPLES=2. Press btn_start bouncing 1-0-1 between db_ticks, then steady high for 2 db_ticks -> exactly one start pulse; state 0->1 two clks after the second steady sample.
2. Up mode, RUN, 61 sec_ticks -> bcd=16'h0101. Start press -> state=2; 5 more sec_ticks -> bcd unchanged. Start press -> state=1.
3. Up mode, clear, force 99:58 via ticks, then 1 sec_tick -> bcd=16'h9959, done=1, state=3. Further ticks and start presses -> unchanged.
4. sw_down=1, load_bcd=16'h0100, clear -> bcd=16'h0100. Start, 1 tick -> 16'h0059. 59 more ticks -> 16'h0000, state=3.
5. Clear and start presses arrive in the same clk while in RUN -> state=0, bcd=clear value. sec_tick coincident with pause press -> bcd unchanged.
6. rst_n pulled low asynchronously mid-RUN with bcd=16'h0342 -> bcd=0000, state=0 before the next clk edge. load_bcd=16'hA7C9 in down mode, clear -> bcd=16'h9759.
